// File: rtl/ascii_hex_pkg.sv
// Shared types and byte constants for the ASCII-hex word parser.
package ascii_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    SKIP  = 2'd3
  } state_t;

  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/hex_char_decode.sv
// Combinational byte classifier: hex digit / delimiter / illegal, with digit value.
// nibble_o is forced to zero for anything that is not a legal digit.
module hex_char_decode
  import ascii_hex_pkg::*;
#(
  parameter int ALLOW_UPPER = 1
) (
  input  logic [7:0] data_i,
  output logic       is_digit_o,
  output logic       is_delim_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_digit_o = 1'b0;
    nibble_o   = 4'd0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      is_digit_o = 1'b1;
      nibble_o   = data_i[3:0];
    end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
      // 'a'..'f' have low nibble 1..6, so +9 gives 10..15; same trick for 'A'..'F'
      is_digit_o = 1'b1;
      nibble_o   = data_i[3:0] + 4'd9;
    end else if ((ALLOW_UPPER != 0) && data_i >= 8'h41 && data_i <= 8'h46) begin
      is_digit_o = 1'b1;
      nibble_o   = data_i[3:0] + 4'd9;
    end
  end

  assign is_delim_o = (data_i == CH_SP) || (data_i == CH_COMMA) ||
                      (data_i == CH_CR) || (data_i == CH_LF);

endmodule

// File: rtl/ascii_hex_word_parser.sv
// Streaming ASCII-hex to binary word parser; emits a right-aligned word on delimiter or full word.
// WORD_W must be a multiple of 4 in 4..64. Illegal bytes pulse err and discard input until a delimiter.
module ascii_hex_word_parser
  import ascii_hex_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ALLOW_UPPER = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_W-1:0]                out_word,
  output logic [$clog2(WORD_W/4+1)-1:0]    out_ndigits,
  output logic                             err
);

  localparam int DIGITS = WORD_W / 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(DIGITS);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic             is_digit, is_delim;
  logic [3:0]       nibble;
  logic             in_fire;
  logic [CNT_W-1:0] cnt_inc;

  hex_char_decode #(
    .ALLOW_UPPER(ALLOW_UPPER)
  ) u_decode (
    .data_i     (in_data),
    .is_digit_o (is_digit),
    .is_delim_o (is_delim),
    .nibble_o   (nibble)
  );

  assign in_ready = (state_q != EMIT);
  assign in_fire  = in_valid & in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (is_digit) begin
            acc_d   = WORD_W'(nibble);
            cnt_d   = CNT_W'(1);
            state_d = (DIGITS == 1) ? EMIT : ACCUM;
          end else if (!is_delim) begin
            err_d   = 1'b1;
            state_d = SKIP;
          end
        end
      end
      ACCUM: begin
        if (in_fire) begin
          if (is_digit) begin
            acc_d = (acc_q << 4) | WORD_W'(nibble);
            cnt_d = cnt_inc;
            if (cnt_inc == DIGITS_C) state_d = EMIT;
          end else if (is_delim) begin
            state_d = EMIT;
          end else begin
            // a partially built word is abandoned, never emitted
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SKIP;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      SKIP: begin
        if (in_fire && is_delim) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid   = (state_q == EMIT);
  assign out_word    = out_valid ? acc_q : '0;
  assign out_ndigits = out_valid ? cnt_q : '0;
  assign err         = err_q;

endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Directed bench: main instance with uppercase enabled, second instance with uppercase disabled.
module tb_ascii_hex_word_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [3:0]  out_ndigits;
  logic        err;

  logic        in_valid_u = 1'b0;
  logic [7:0]  in_data_u = 8'h00;
  logic        in_ready_u;
  logic        out_valid_u;
  logic [31:0] out_word_u;
  logic [3:0]  out_ndigits_u;
  logic        err_u;

  int passed = 0;
  int total  = 0;
  int err_cnt = 0;
  int err_u_cnt = 0;
  int ov_u_cnt = 0;
  logic [31:0] wq[$];
  logic [3:0]  nq[$];

  always #5 clk = ~clk;

  ascii_hex_word_parser #(.WORD_W(32), .ALLOW_UPPER(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_ndigits(out_ndigits), .err(err)
  );

  ascii_hex_word_parser #(.WORD_W(32), .ALLOW_UPPER(0)) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_u), .in_ready(in_ready_u), .in_data(in_data_u),
    .out_valid(out_valid_u), .out_ready(1'b1),
    .out_word(out_word_u), .out_ndigits(out_ndigits_u), .err(err_u)
  );

  // Record completed handshakes and error pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        wq.push_back(out_word);
        nq.push_back(out_ndigits);
      end
      if (err) err_cnt++;
      if (err_u) err_u_cnt++;
      if (out_valid_u) ov_u_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the transfer edge
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    if (sel) begin in_valid_u = 1'b1; in_data_u = b; end
    else begin in_valid = 1'b1; in_data = b; end
    while (((sel ? in_ready_u : in_ready) == 1'b0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_ready_wait", sel ? in_ready_u : in_ready, 1'b1);
    @(posedge clk);
    #1;
    if (sel) in_valid_u = 1'b0;
    else in_valid = 1'b0;
  endtask

  task automatic send_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i]);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] w, input logic [3:0] nd);
    logic [31:0] ow;
    logic [3:0]  on;
    ow = 'x;
    on = 'x;
    if (wq.size() > 0) begin
      ow = wq.pop_front();
      on = nq.pop_front();
    end
    chk({tag, "_word"}, ow, w);
    chk({tag, "_ndig"}, on, nd);
  endtask

  initial begin
    int e0;
    cycles(2);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_ndig", out_ndigits, 4'd0);
    chk("rst_err", err, 1'b0);

    // 1: basic lowercase word
    e0 = err_cnt;
    send_str(0, "1f3\n");
    cycles(3);
    chk("t1_count", wq.size(), 1);
    pop_chk("t1", 32'h000001F3, 4'd3);
    chk("t1_err", err_cnt - e0, 0);

    // 2: full word without delimiter, then a new word
    send_str(0, "DEADBEEF1\n");
    cycles(3);
    chk("t2_count", wq.size(), 2);
    pop_chk("t2a", 32'hDEADBEEF, 4'd8);
    pop_chk("t2b", 32'h00000001, 4'd1);

    // 3: illegal character mid-word
    e0 = err_cnt;
    send_str(0, "12g");
    chk("t3_err_pulse", err, 1'b1);
    send_byte(0, "4");
    chk("t3_err_once", err, 1'b0);
    send_str(0, " 5\n");
    cycles(3);
    chk("t3_err_cnt", err_cnt - e0, 1);
    chk("t3_count", wq.size(), 1);
    pop_chk("t3", 32'h5, 4'd1);

    // 4: output backpressure
    out_ready = 1'b0;
    send_str(0, "ab\n");
    for (int i = 0; i < 5; i++) begin
      chk("t4_out_valid", out_valid, 1'b1);
      chk("t4_out_word", out_word, 32'h000000AB);
      chk("t4_in_ready", in_ready, 1'b0);
      cycles(1);
    end
    out_ready = 1'b1;
    cycles(1);
    chk("t4_valid_drop", out_valid, 1'b0);
    chk("t4_in_ready_back", in_ready, 1'b1);
    cycles(3);
    chk("t4_count", wq.size(), 1);
    pop_chk("t4", 32'h000000AB, 4'd2);

    // 5: reset discards partial word and the byte presented during reset
    send_str(0, "ab");
    cycles(3);
    chk("t5_no_out", wq.size(), 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = "9";
    cycles(1);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("t5_post_rst_valid", out_valid, 1'b0);
    chk("t5_post_rst_ready", in_ready, 1'b1);
    send_str(0, "7 ");
    cycles(3);
    chk("t5_count", wq.size(), 1);
    pop_chk("t5", 32'h7, 4'd1);

    // 6: delimiters only; uppercase rejected when disabled
    e0 = err_cnt;
    send_str(0, "  ,\r\n");
    cycles(3);
    chk("t6_no_out", wq.size(), 0);
    chk("t6_no_err", err_cnt - e0, 0);
    send_byte(1, "A");
    chk("t6_upper_err", err_u, 1'b1);
    send_str(1, " ");
    cycles(3);
    chk("t6_upper_err_cnt", err_u_cnt, 1);
    chk("t6_upper_no_out", ov_u_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
